// File: rtl/note_player_pkg.sv
// ---------------------------------------------------------------------------
// note_player_pkg : shared widths, timing constants and FSM encoding
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package note_player_pkg;

  localparam int c_NOTE_W      = 6;
  localparam int c_DUR_W       = 6;
  localparam int c_STEP_W      = 20;
  localparam int c_SAMPLE_RATE = 48000;
  localparam int c_PHASE_W     = 22;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PLAYING = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/note_freq_rom.sv
// ---------------------------------------------------------------------------
// note_freq_rom : note index -> phase step, round(f/48000 * 2^22), A4 = 49
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module note_freq_rom
  import note_player_pkg::*;
#(
  parameter int NOTE_W = c_NOTE_W,
  parameter int STEP_W = c_STEP_W
) (
  input  logic [NOTE_W-1:0] note,
  output logic [STEP_W-1:0] step_size
);

  // Equal-tempered piano-key numbering: key 1 = A0 (27.5 Hz), index 0 is a rest
  localparam logic [19:0] c_TABLE [0:63] = '{
    20'd0,
    20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,
    20'd3398,  20'd3600,  20'd3815,  20'd4041,  20'd4282,  20'd4536,
    20'd4806,  20'd5092,  20'd5395,  20'd5715,  20'd6055,  20'd6415,
    20'd6797,  20'd7201,  20'd7629,  20'd8083,  20'd8563,  20'd9072,
    20'd9612,  20'd10184, 20'd10789, 20'd11431, 20'd12110, 20'd12830,
    20'd13593, 20'd14402, 20'd15258, 20'd16165, 20'd17127, 20'd18145,
    20'd19224, 20'd20367, 20'd21578, 20'd22861, 20'd24221, 20'd25661,
    20'd27187, 20'd28803, 20'd30516, 20'd32331, 20'd34253, 20'd36290,
    20'd38448, 20'd40734, 20'd43156, 20'd45722, 20'd48441, 20'd51322,
    20'd54373, 20'd57607, 20'd61032, 20'd64661, 20'd68506, 20'd72580,
    20'd76896, 20'd81468, 20'd86312
  };

  always_comb begin
    step_size = STEP_W'(c_TABLE[note]);
  end

endmodule

`default_nettype wire

// File: rtl/note_player.sv
// ---------------------------------------------------------------------------
// note_player : plays one note for its beat count, feeding the sine reader
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module note_player
  import note_player_pkg::*;
#(
  parameter int NOTE_W = c_NOTE_W,
  parameter int DUR_W  = c_DUR_W,
  parameter int STEP_W = c_STEP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              load_new_note,
  input  logic [NOTE_W-1:0] note_to_load,
  input  logic [DUR_W-1:0]  duration_to_load,
  input  logic              beat,
  input  logic              generate_next_sample,
  output logic [STEP_W-1:0] step_size,
  output logic              generate_next,
  output logic              done_with_note,
  output logic              busy
);

  state_t             r_state;
  logic [DUR_W-1:0]   r_dur_cnt;
  logic [STEP_W-1:0]  w_rom_step;
  logic               w_playing;
  logic               w_counted_beat;

  note_freq_rom #(
    .NOTE_W (NOTE_W),
    .STEP_W (STEP_W)
  ) u_rom (
    .note      (note_to_load),
    .step_size (w_rom_step)
  );

  assign w_playing      = (r_state == ST_PLAYING);
  // A load in the same cycle takes priority, so that beat belongs to no note
  assign w_counted_beat = beat & play_enable & w_playing & ~load_new_note;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_dur_cnt      <= '0;
      step_size      <= '0;
      generate_next  <= 1'b0;
      done_with_note <= 1'b0;
      busy           <= 1'b0;
    end else begin
      generate_next  <= generate_next_sample & play_enable & w_playing;
      done_with_note <= 1'b0;
      if (load_new_note) begin
        if (duration_to_load != '0) begin
          r_state   <= ST_PLAYING;
          r_dur_cnt <= duration_to_load;
          step_size <= w_rom_step;
          busy      <= 1'b1;
        end else begin
          r_state        <= ST_IDLE;
          r_dur_cnt      <= '0;
          step_size      <= '0;
          busy           <= 1'b0;
          done_with_note <= 1'b1;
        end
      end else if (w_counted_beat) begin
        if (r_dur_cnt == DUR_W'(1)) begin
          r_state        <= ST_IDLE;
          r_dur_cnt      <= '0;
          step_size      <= '0;
          busy           <= 1'b0;
          done_with_note <= 1'b1;
        end else if (r_dur_cnt != '0) begin
          r_dur_cnt <= r_dur_cnt - DUR_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_note_player.sv
// ---------------------------------------------------------------------------
// tb_note_player : directed scenarios for note_player with inline checks
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_note_player;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        play_enable = 1'b0;
  logic        load_new_note = 1'b0;
  logic [5:0]  note_to_load = '0;
  logic [5:0]  duration_to_load = '0;
  logic        beat = 1'b0;
  logic        generate_next_sample = 1'b0;
  logic [19:0] step_size;
  logic        generate_next;
  logic        done_with_note;
  logic        busy;

  int errors = 0;
  int checks = 0;

  localparam logic [19:0] c_STEP_A4  = 20'd38448;
  localparam logic [19:0] c_STEP_N10 = 20'd4041;

  note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .load_new_note        (load_new_note),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .step_size            (step_size),
    .generate_next        (generate_next),
    .done_with_note       (done_with_note),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] n, input logic [5:0] d);
    note_to_load = n; duration_to_load = d; load_new_note = 1'b1;
    tick();
    load_new_note = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_new_note = (i != 1); note_to_load = 6'd49; duration_to_load = 6'd3;
      beat = (i != 0); generate_next_sample = 1'b1; play_enable = (i != 2);
      tick();
      checks++; if (step_size !== 20'd0) begin errors++; $display("FAIL reset_step[%0d]: got %0d want 0", i, step_size); end
      checks++; if (generate_next !== 1'b0) begin errors++; $display("FAIL reset_gen[%0d]: got %b want 0", i, generate_next); end
      checks++; if (done_with_note !== 1'b0) begin errors++; $display("FAIL reset_done[%0d]: got %b want 0", i, done_with_note); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy); end
    end
    load_new_note = 1'b0; beat = 1'b0; generate_next_sample = 1'b0; play_enable = 1'b1;
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_note_a4();
    load(6'd49, 6'd3);
    checks++; if (step_size !== c_STEP_A4) begin errors++; $display("FAIL a4_step: got %0d want %0d", step_size, c_STEP_A4); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a4_busy: got %b want 1", busy); end
    tick(); tick();
    for (int b = 1; b <= 3; b++) begin
      pulse_beat();
      checks++; if (done_with_note !== (b == 3)) begin errors++; $display("FAIL a4_done_beat%0d: got %b want %b", b, done_with_note, (b == 3)); end
      checks++; if (busy !== (b != 3)) begin errors++; $display("FAIL a4_busy_beat%0d: got %b want %b", b, busy, (b != 3)); end
      tick();
    end
    checks++; if (step_size !== 20'd0) begin errors++; $display("FAIL a4_step_after: got %0d want 0", step_size); end
    checks++; if (done_with_note !== 1'b0) begin errors++; $display("FAIL a4_done_once: got %b want 0", done_with_note); end
  endtask

  task automatic test_codec_requests();
    load(6'd49, 6'd2);
    for (int i = 0; i < 12; i++) begin
      generate_next_sample = (i % 4 == 0);
      tick();
      checks++; if (generate_next !== (i % 4 == 0)) begin errors++; $display("FAIL gen_follow[%0d]: got %b want %b", i, generate_next, (i % 4 == 0)); end
    end
    generate_next_sample = 1'b0;
    pulse_beat(); pulse_beat();
    checks++; if (done_with_note !== 1'b1) begin errors++; $display("FAIL gen_done: got %b want 1", done_with_note); end
    for (int i = 0; i < 3; i++) begin
      generate_next_sample = 1'b1;
      tick();
      checks++; if (generate_next !== (i == 0 ? 1'b0 : 1'b0)) begin errors++; $display("FAIL gen_after_done[%0d]: got %b want 0", i, generate_next); end
    end
    generate_next_sample = 1'b0;
    tick();
  endtask

  task automatic test_pause();
    load(6'd49, 6'd3);
    pulse_beat();
    play_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      beat = 1'b1; generate_next_sample = 1'b1;
      tick();
      beat = 1'b0;
      checks++; if (generate_next !== 1'b0) begin errors++; $display("FAIL pause_gen[%0d]: got %b want 0", i, generate_next); end
      checks++; if (step_size !== c_STEP_A4) begin errors++; $display("FAIL pause_step[%0d]: got %0d want %0d", i, step_size, c_STEP_A4); end
      checks++; if (done_with_note !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pause_hold[%0d]: got done=%b busy=%b want done=0 busy=1", i, done_with_note, busy); end
      generate_next_sample = 1'b0;
      tick();
    end
    play_enable = 1'b1;
    pulse_beat();
    checks++; if (done_with_note !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL resume_beat2: got done=%b busy=%b want done=0 busy=1", done_with_note, busy); end
    tick();
    pulse_beat();
    checks++; if (done_with_note !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL resume_beat3: got done=%b busy=%b want done=1 busy=0", done_with_note, busy); end
    tick();
  endtask

  task automatic test_load_override();
    load(6'd49, 6'd4);
    pulse_beat();
    beat = 1'b1;
    load(6'd10, 6'd2);
    beat = 1'b0;
    checks++; if (step_size !== c_STEP_N10) begin errors++; $display("FAIL ovr_step: got %0d want %0d", step_size, c_STEP_N10); end
    checks++; if (done_with_note !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovr_no_old_done: got done=%b busy=%b want done=0 busy=1", done_with_note, busy); end
    pulse_beat();
    checks++; if (done_with_note !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovr_beat_not_counted: got done=%b busy=%b want done=0 busy=1", done_with_note, busy); end
    load(6'd10, 6'd0);
    checks++; if (done_with_note !== 1'b1) begin errors++; $display("FAIL zero_dur_done: got %b want 1", done_with_note); end
    checks++; if (busy !== 1'b0 || step_size !== 20'd0) begin errors++; $display("FAIL zero_dur_idle: got busy=%b step=%0d want busy=0 step=0", busy, step_size); end
    tick();
    checks++; if (done_with_note !== 1'b0) begin errors++; $display("FAIL zero_dur_pulse_len: got %b want 0", done_with_note); end
  endtask

  task automatic test_reset_mid_note();
    load(6'd49, 6'd4);
    pulse_beat(); pulse_beat();
    reset = 1'b0; generate_next_sample = 1'b1;
    tick();
    reset = 1'b1; generate_next_sample = 1'b0;
    checks++; if (step_size !== 20'd0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_out: got step=%0d busy=%b want step=0 busy=0", step_size, busy); end
    checks++; if (done_with_note !== 1'b0 || generate_next !== 1'b0) begin errors++; $display("FAIL midrst_strobes: got done=%b gen=%b want 0 0", done_with_note, generate_next); end
    for (int i = 0; i < 2; i++) begin
      pulse_beat();
      checks++; if (done_with_note !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_idle[%0d]: got done=%b busy=%b want 0 0", i, done_with_note, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_note_a4();
    test_codec_requests();
    test_pause();
    test_load_override();
    test_reset_mid_note();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
